// File: rtl/cgra_config_loader.sv
// Host-side configuration writer for the CGRA PE array: decodes a valid/ready word stream
// into one-cycle per-PE config strobes, then pulses start_exec and tracks the run state.
module cgra_config_loader #(
    parameter int PE_NUM                  = 16,
    parameter int PE_ID_WIDTH             = 4,
    parameter int CONTEXT_SIZE            = 8,
    parameter int CONTEXT_SIZE_BIT_LENGTH = 3,
    parameter int INPUT_NUM_BIT_LENGTH    = 3,
    parameter int OPERATION_BIT_LENGTH    = 4,
    parameter int DATA_WIDTH              = 32
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               cfg_valid,
    output logic                               cfg_ready,
    input  logic                               cfg_last,
    input  logic [PE_ID_WIDTH-1:0]             cfg_pe_id,
    input  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] cfg_context,
    input  logic [INPUT_NUM_BIT_LENGTH-1:0]    cfg_input_1,
    input  logic [INPUT_NUM_BIT_LENGTH-1:0]    cfg_input_2,
    input  logic [OPERATION_BIT_LENGTH-1:0]    cfg_op,
    input  logic [DATA_WIDTH-1:0]              cfg_const,
    input  logic                               exec_stop,
    output logic [PE_NUM-1:0]                  write_config_data,
    output logic [CONTEXT_SIZE_BIT_LENGTH-1:0] config_index,
    output logic [INPUT_NUM_BIT_LENGTH-1:0]    config_input_PE_index_1,
    output logic [INPUT_NUM_BIT_LENGTH-1:0]    config_input_PE_index_2,
    output logic [OPERATION_BIT_LENGTH-1:0]    config_op,
    output logic [DATA_WIDTH-1:0]              config_const_data,
    output logic                               start_exec,
    output logic [CONTEXT_SIZE_BIT_LENGTH-1:0] mapping_context_max_id,
    output logic                               running,
    output logic                               cfg_error
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_FLUSH = 3'd2;
    localparam logic [2:0] S_START = 3'd3;
    localparam logic [2:0] S_RUN   = 3'd4;

    logic [2:0]                         state_q, state_d;
    logic                               cfg_ready_q, cfg_ready_d;
    logic [PE_NUM-1:0]                  strobe_q, strobe_d;
    logic [CONTEXT_SIZE_BIT_LENGTH-1:0] index_q, index_d;
    logic [INPUT_NUM_BIT_LENGTH-1:0]    in1_q, in1_d;
    logic [INPUT_NUM_BIT_LENGTH-1:0]    in2_q, in2_d;
    logic [OPERATION_BIT_LENGTH-1:0]    op_q, op_d;
    logic [DATA_WIDTH-1:0]              const_q, const_d;
    logic                               start_q, start_d;
    logic                               running_q, running_d;
    logic                               error_q, error_d;
    logic [CONTEXT_SIZE_BIT_LENGTH-1:0] max_track_q, max_track_d;
    logic [CONTEXT_SIZE_BIT_LENGTH-1:0] max_out_q, max_out_d;

    logic                               accept;
    logic                               bad_word;
    logic                               new_load;
    logic [CONTEXT_SIZE_BIT_LENGTH-1:0] max_base;
    logic [CONTEXT_SIZE_BIT_LENGTH-1:0] max_next;

    always_comb begin
        accept   = cfg_valid && cfg_ready_q;
        bad_word = (32'(cfg_pe_id) >= PE_NUM) || (32'(cfg_context) >= CONTEXT_SIZE);
        new_load = accept && (state_q == S_IDLE);
        // A new load restarts the tracker from 0 before folding in its first word.
        max_base = new_load ? '0 : max_track_q;
        max_next = (!bad_word && (cfg_context > max_base)) ? cfg_context : max_base;

        state_d     = state_q;
        strobe_d    = '0;
        index_d     = index_q;
        in1_d       = in1_q;
        in2_d       = in2_q;
        op_d        = op_q;
        const_d     = const_q;
        error_d     = error_q;
        max_track_d = max_track_q;
        max_out_d   = max_out_q;

        case (state_q)
            S_IDLE, S_LOAD: if (accept) state_d = cfg_last ? S_FLUSH : S_LOAD;
            S_FLUSH:        state_d = S_START;
            S_START:        state_d = S_RUN;
            S_RUN:          if (exec_stop) state_d = S_IDLE;
            default:        state_d = S_IDLE;
        endcase

        if (accept) begin
            max_track_d = max_next;
            error_d     = (new_load ? 1'b0 : error_q) | bad_word;
            if (cfg_last) max_out_d = max_next;
            if (!bad_word) begin
                strobe_d = {{(PE_NUM-1){1'b0}}, 1'b1} << cfg_pe_id;
                index_d  = cfg_context;
                in1_d    = cfg_input_1;
                in2_d    = cfg_input_2;
                op_d     = cfg_op;
                const_d  = cfg_const;
            end
        end

        cfg_ready_d = (state_d == S_IDLE) || (state_d == S_LOAD);
        start_d     = (state_d == S_START);
        running_d   = (state_d == S_RUN);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cfg_ready_q <= 1'b0;
            strobe_q    <= '0;
            index_q     <= '0;
            in1_q       <= '0;
            in2_q       <= '0;
            op_q        <= '0;
            const_q     <= '0;
            start_q     <= 1'b0;
            running_q   <= 1'b0;
            error_q     <= 1'b0;
            max_track_q <= '0;
            max_out_q   <= '0;
        end else begin
            state_q     <= state_d;
            cfg_ready_q <= cfg_ready_d;
            strobe_q    <= strobe_d;
            index_q     <= index_d;
            in1_q       <= in1_d;
            in2_q       <= in2_d;
            op_q        <= op_d;
            const_q     <= const_d;
            start_q     <= start_d;
            running_q   <= running_d;
            error_q     <= error_d;
            max_track_q <= max_track_d;
            max_out_q   <= max_out_d;
        end
    end

    assign cfg_ready               = cfg_ready_q;
    assign write_config_data       = strobe_q;
    assign config_index            = index_q;
    assign config_input_PE_index_1 = in1_q;
    assign config_input_PE_index_2 = in2_q;
    assign config_op               = op_q;
    assign config_const_data       = const_q;
    assign start_exec              = start_q;
    assign running                 = running_q;
    assign cfg_error               = error_q;
    assign mapping_context_max_id  = max_out_q;

endmodule
